// File: rtl/capture_ctrl_pkg.sv
// Constants and state encoding shared by capture_ctrl, cmd_cfg and the dump logic.
package la_pkg;

  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// Sample strobe, trigger status and RAMqueue write port seen by the capture controller.
interface capture_ctrl_if #(
  parameter int LOG2 = la_pkg::LOG2
) ();

  logic            wrt_smpl;
  logic            run;
  logic            capture_done;
  logic            triggered;
  logic [LOG2-1:0] trig_pos;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic            armed;
  logic            set_capture_done;

  // The capture controller is the master: it owns the write port and status outputs.
  modport master (
    input  wrt_smpl, run, capture_done, triggered, trig_pos,
    output we, waddr, armed, set_capture_done
  );

  modport slave (
    output wrt_smpl, run, capture_done, triggered, trig_pos,
    input  we, waddr, armed, set_capture_done
  );

endinterface

// File: rtl/capture_ctrl.sv
// Writes kept samples into the circular RAMqueue, arms the trigger once the
// pre-trigger region is full and stops after trig_pos post-trigger samples.
module capture_ctrl #(
  parameter int ENTRIES = la_pkg::ENTRIES,
  parameter int LOG2    = la_pkg::LOG2
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.master bus
);

  import la_pkg::*;

  localparam logic [LOG2:0]   ENTRIES_W = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0]   ONE_W     = (LOG2+1)'(1);
  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  cap_state_t      state;
  cap_state_t      state_next;
  logic [LOG2-1:0] waddr;
  logic [LOG2:0]   smpl_cnt;
  logic [LOG2:0]   trig_cnt;
  logic            armed;
  logic            set_done;

  logic            start;
  logic            write;
  logic [LOG2:0]   smpl_inc;
  logic [LOG2:0]   arm_sum;
  logic [LOG2:0]   trig_inc;
  logic            arm_hit;
  logic            trig_write;
  logic            complete;

  // Dropping run suppresses the write in the same cycle.
  assign write = (state == CAPTURE) && bus.run && bus.wrt_smpl;

  always_comb begin
    smpl_inc   = (smpl_cnt >= ENTRIES_W) ? smpl_cnt : smpl_cnt + ONE_W;
    arm_sum    = smpl_inc + {1'b0, bus.trig_pos};
    arm_hit    = write && (arm_sum >= ENTRIES_W);
    trig_write = write && bus.triggered && armed;
    trig_inc   = trig_cnt + ONE_W;
    // trig_pos of 0 is satisfied by the first armed trigger write, same as 1.
    complete   = trig_write && (trig_inc >= {1'b0, bus.trig_pos});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.run && !bus.capture_done) begin
          start      = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!bus.run)     state_next = IDLE;
        else if (complete) state_next = DONE;
      end
      DONE: begin
        if (!bus.capture_done || !bus.run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // armed is sticky until the next capture starts so the trigger logic
  // keeps seeing it through DONE and the dump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr    <= '0;
      smpl_cnt <= '0;
      trig_cnt <= '0;
      armed    <= 1'b0;
      set_done <= 1'b0;
    end else begin
      set_done <= complete;
      if (start) begin
        waddr    <= '0;
        smpl_cnt <= '0;
        trig_cnt <= '0;
        armed    <= 1'b0;
      end else if (write) begin
        waddr    <= (waddr == LAST_ADDR) ? '0 : waddr + 1'b1;
        smpl_cnt <= smpl_inc;
        if (arm_hit)    armed    <= 1'b1;
        if (trig_write) trig_cnt <= trig_inc;
      end
    end
  end

  assign bus.we               = write;
  assign bus.waddr            = waddr;
  assign bus.armed            = armed;
  assign bus.set_capture_done = set_done;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: reset, arming, completion, trig_pos edges, abort/restart.
module tb_capture_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  capture_ctrl_if bus ();

  capture_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; registered outputs are read there too.
  task automatic apply_stimulus(input logic ws, input logic trg);
    @(negedge clk);
    bus.wrt_smpl  = ws;
    bus.triggered = trg;
  endtask

  task automatic write_n(input int n, input logic trg);
    for (int i = 0; i < n; i++) apply_stimulus(1'b1, trg);
    apply_stimulus(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n            = 1'b0;
    bus.wrt_smpl     = 1'b0;
    bus.run          = 1'b0;
    bus.capture_done = 1'b0;
    bus.triggered    = 1'b0;
    bus.trig_pos     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_capture(input int tp);
    @(negedge clk);
    bus.trig_pos = 9'(tp);
    bus.run      = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.wrt_smpl     = 1'b0;
    bus.run          = 1'b0;
    bus.capture_done = 1'b0;
    bus.triggered    = 1'b0;
    bus.trig_pos     = '0;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.waddr !== 9'd0 || bus.armed !== 1'b0 || bus.set_capture_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_initial: we=%b waddr=%0d armed=%b scd=%b, required all 0",
               bus.we, bus.waddr, bus.armed, bus.set_capture_done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    start_capture(383);
    write_n(5, 1'b0);
    checks++;
    if (bus.armed !== 1'b1 || bus.waddr !== 9'd5) begin
      failures++;
      $display("[TB] FAIL reset_precond: armed=%b waddr=%0d, required 1 and 5", bus.armed, bus.waddr);
    end
    apply_stimulus(1'b1, 1'b0);
    #1;
    checks++;
    if (bus.we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_we_before: we=%b, required 1", bus.we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.we !== 1'b0 || bus.waddr !== 9'd0 || bus.armed !== 1'b0 || bus.set_capture_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_async: we=%b waddr=%0d armed=%b scd=%b, required all 0",
               bus.we, bus.waddr, bus.armed, bus.set_capture_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_we: we=%b, required 0", bus.we);
    end
    apply_stimulus(1'b0, 1'b0);
    checks++;
    if (bus.waddr !== 9'd0 || bus.set_capture_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: waddr=%0d scd=%b, required 0 and 0", bus.waddr, bus.set_capture_done);
    end
  endtask

  task automatic test_arming_completion();
    apply_reset();
    start_capture(10);
    write_n(373, 1'b1);
    checks++;
    if (bus.armed !== 1'b0 || bus.waddr !== 9'd373 || bus.set_capture_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arm_before: armed=%b waddr=%0d scd=%b, required 0 373 0",
               bus.armed, bus.waddr, bus.set_capture_done);
    end
    write_n(1, 1'b0);
    checks++;
    if (bus.armed !== 1'b1) begin
      failures++;
      $display("[TB] FAIL arm_after_374: armed=%b, required 1", bus.armed);
    end
    write_n(25, 1'b0);
    write_n(9, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b0 || bus.waddr !== 9'd24) begin
      failures++;
      $display("[TB] FAIL complete_early: scd=%b waddr=%0d, required 0 and 24", bus.set_capture_done, bus.waddr);
    end
    apply_stimulus(1'b1, 1'b1);
    #1;
    checks++;
    if (bus.we !== 1'b1) begin
      failures++;
      $display("[TB] FAIL complete_last_we: we=%b, required 1", bus.we);
    end
    apply_stimulus(1'b1, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b1 || bus.waddr !== 9'd25) begin
      failures++;
      $display("[TB] FAIL complete_pulse: scd=%b waddr=%0d, required 1 and 25", bus.set_capture_done, bus.waddr);
    end
    #1;
    checks++;
    if (bus.we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL done_we: we=%b, required 0", bus.we);
    end
    bus.capture_done = 1'b1;
  endtask

  task automatic test_done_hold();
    int we_seen;
    int pulse_seen;
    we_seen    = 0;
    pulse_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(1'b1, 1'b1);
      #1;
      if (bus.we === 1'b1) we_seen++;
      if (bus.set_capture_done === 1'b1) pulse_seen++;
    end
    checks++;
    if (we_seen !== 0 || pulse_seen !== 0 || bus.waddr !== 9'd25) begin
      failures++;
      $display("[TB] FAIL done_hold: writes=%0d pulses=%0d waddr=%0d, required 0 0 25", we_seen, pulse_seen, bus.waddr);
    end
  endtask

  task automatic test_restart_abort();
    apply_stimulus(1'b0, 1'b0);
    bus.capture_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.waddr !== 9'd0 || bus.armed !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_clear: waddr=%0d armed=%b, required 0 and 0", bus.waddr, bus.armed);
    end
    write_n(3, 1'b0);
    checks++;
    if (bus.waddr !== 9'd3) begin
      failures++;
      $display("[TB] FAIL restart_writes: waddr=%0d, required 3", bus.waddr);
    end
    apply_stimulus(1'b1, 1'b0);
    bus.run = 1'b0;
    #1;
    checks++;
    if (bus.we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_we: we=%b, required 0", bus.we);
    end
    repeat (3) apply_stimulus(1'b1, 1'b1);
    #1;
    checks++;
    if (bus.set_capture_done !== 1'b0 || bus.we !== 1'b0 || bus.waddr !== 9'd3) begin
      failures++;
      $display("[TB] FAIL abort_idle: scd=%b we=%b waddr=%0d, required 0 0 3",
               bus.set_capture_done, bus.we, bus.waddr);
    end
    apply_stimulus(1'b0, 1'b0);
    bus.run = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.waddr !== 9'd0) begin
      failures++;
      $display("[TB] FAIL abort_restart: waddr=%0d, required 0", bus.waddr);
    end
  endtask

  task automatic test_trig_pos_zero();
    apply_reset();
    start_capture(0);
    write_n(383, 1'b0);
    checks++;
    if (bus.armed !== 1'b0 || bus.waddr !== 9'd383) begin
      failures++;
      $display("[TB] FAIL tp0_not_armed: armed=%b waddr=%0d, required 0 and 383", bus.armed, bus.waddr);
    end
    write_n(1, 1'b0);
    checks++;
    if (bus.armed !== 1'b1 || bus.waddr !== 9'd0) begin
      failures++;
      $display("[TB] FAIL tp0_wrap_arm: armed=%b waddr=%0d, required 1 and 0", bus.armed, bus.waddr);
    end
    write_n(1, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b1 || bus.waddr !== 9'd1) begin
      failures++;
      $display("[TB] FAIL tp0_complete: scd=%b waddr=%0d, required 1 and 1", bus.set_capture_done, bus.waddr);
    end
    bus.run = 1'b0;
  endtask

  task automatic test_trig_pos_max();
    apply_reset();
    start_capture(383);
    write_n(1, 1'b0);
    checks++;
    if (bus.armed !== 1'b1) begin
      failures++;
      $display("[TB] FAIL tp383_armed: armed=%b, required 1", bus.armed);
    end
    write_n(382, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b0 || bus.waddr !== 9'd383) begin
      failures++;
      $display("[TB] FAIL tp383_early: scd=%b waddr=%0d, required 0 and 383", bus.set_capture_done, bus.waddr);
    end
    write_n(1, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b1 || bus.waddr !== 9'd0) begin
      failures++;
      $display("[TB] FAIL tp383_wrap_done: scd=%b waddr=%0d, required 1 and 0", bus.set_capture_done, bus.waddr);
    end
    apply_stimulus(1'b1, 1'b1);
    checks++;
    if (bus.set_capture_done !== 1'b0 || bus.waddr !== 9'd0) begin
      failures++;
      $display("[TB] FAIL tp383_single_pulse: scd=%b waddr=%0d, required 0 and 0", bus.set_capture_done, bus.waddr);
    end
    bus.run = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_arming_completion();
    test_done_hold();
    test_restart_abort();
    test_trig_pos_zero();
    test_trig_pos_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
